// File: rtl/ariane_pkg.sv
// Shared types and sizing for the scoreboard slice: entry record, exception record, FU kinds.
// Consumed by scoreboard and, when SB_FORWARD_EN is defined, sb_fwd_lookup.
package ariane_pkg;

  localparam int NR_SB_ENTRIES = 4;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int NR_WB_PORTS   = 2;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    ALU  = 3'd1,
    LSU  = 3'd2,
    MULT = 3'd3,
    CSR  = 3'd4
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/sb_fwd_lookup.sv
// Age-ordered rd match over allocated scoreboard entries (youngest first) for operand forwarding.
// Only compiled when SB_FORWARD_EN is defined.
`ifdef SB_FORWARD_EN
module sb_fwd_lookup
  import ariane_pkg::*;
#(
  parameter int NR_ENTRIES = NR_SB_ENTRIES
) (
  input  logic [4:0]                   rs_i,
  input  logic [NR_ENTRIES-1:0]        alloc_i,
  input  logic [NR_ENTRIES-1:0]        done_i,
  input  logic [NR_ENTRIES-1:0][4:0]   rd_i,
  input  logic [NR_ENTRIES-1:0][63:0]  result_i,
  input  logic [TRANS_ID_BITS-1:0]     tail_i,
  output logic [63:0]                  operand_o,
  output logic                         operand_valid_o
);

  // Allocated entries are contiguous from head to tail-1, so walking back from tail-1
  // visits them youngest to oldest; the first match is the producer we depend on.
  always_comb begin
    logic                     hit;
    logic [TRANS_ID_BITS-1:0] idx;
    hit             = 1'b0;
    idx             = '0;
    operand_o       = '0;
    operand_valid_o = 1'b0;
    for (int k = 0; k < NR_ENTRIES; k++) begin
      idx = tail_i - TRANS_ID_BITS'(k + 1);
      if (!hit && rs_i != 5'd0 && alloc_i[idx] && rd_i[idx] == rs_i) begin
        hit             = 1'b1;
        operand_o       = result_i[idx];
        operand_valid_o = done_i[idx];
      end
    end
  end

endmodule
`endif

// File: rtl/scoreboard.sv
// In-order allocate / out-of-order writeback / in-order commit tracker of in-flight instructions.
// Define SB_FORWARD_EN to add rs1/rs2 operand forwarding ports backed by sb_fwd_lookup.
module scoreboard
  import ariane_pkg::*;
#(
  parameter int NR_ENTRIES  = NR_SB_ENTRIES,
  parameter int NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  output logic                                         full_o,
  input  scoreboard_entry                              decoded_instr_i,
  input  logic                                         decoded_valid_i,
  output scoreboard_entry                              issue_instr_o,
  output logic                                         issue_valid_o,
  input  logic                                         issue_ack_i,
  output logic [31:0]                                  rd_busy_o,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                 wb_data_i,
  input  exception [NR_WB_PORTS-1:0]                   wb_ex_i,
  output scoreboard_entry                              commit_instr_o,
  output logic                                         commit_valid_o,
  input  logic                                         commit_ack_i
`ifdef SB_FORWARD_EN
  ,
  input  logic [4:0]                                   rs1_i,
  input  logic [4:0]                                   rs2_i,
  output logic [63:0]                                  rs1_o,
  output logic [63:0]                                  rs2_o,
  output logic                                         rs1_valid_o,
  output logic                                         rs2_valid_o
`endif
);

  scoreboard_entry          mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]    alloc;
  logic [NR_ENTRIES-1:0]    done;
  logic [TRANS_ID_BITS-1:0] head;
  logic [TRANS_ID_BITS-1:0] tail;
  logic [TRANS_ID_BITS:0]   count;
  logic                     clear;
  logic                     do_alloc;
  logic                     do_commit;
  logic                     wb_conflict;
  logic                     unused_trans_id;

  assign clear          = rst_i | flush_i;
  assign full_o         = (count == (TRANS_ID_BITS + 1)'(NR_ENTRIES));
  assign issue_valid_o  = decoded_valid_i & ~full_o;
  assign do_alloc       = issue_valid_o & issue_ack_i;
  assign commit_valid_o = alloc[head] & done[head];
  assign do_commit      = commit_valid_o & commit_ack_i;

  // Incoming trans_id is always replaced by the tail index.
  assign unused_trans_id = ^decoded_instr_i.trans_id;

  always_comb begin
    issue_instr_o          = decoded_instr_i;
    issue_instr_o.trans_id = tail;
  end

  // Control state: pointers, occupancy, allocation and result-valid bits.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      alloc <= '0;
      done  <= '0;
    end else begin
      if (do_alloc) begin
        alloc[tail] <= 1'b1;
        done[tail]  <= decoded_instr_i.valid;
        tail        <= tail + 1'b1;
      end
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && alloc[wb_trans_id_i[p]]) begin
          done[wb_trans_id_i[p]] <= 1'b1;
        end
      end
      // NOTE: non-blocking writes to the same bit resolve last-wins, so the commit clear
      // below overrides any writeback to the head issued in the same cycle.
      if (do_commit) begin
        alloc[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry payload carries no reset; alloc/done gate every use of it, which keeps
  // the array free of a reset fan-out.
  always_ff @(posedge clk_i) begin
    if (!clear) begin
      if (do_alloc) begin
        mem[tail] <= issue_instr_o;
      end
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && alloc[wb_trans_id_i[p]]) begin
          mem[wb_trans_id_i[p]].result <= wb_data_i[p];
          if (wb_ex_i[p].valid) begin
            mem[wb_trans_id_i[p]].ex <= wb_ex_i[p];
          end
        end
      end
    end
  end

  always_comb begin
    commit_instr_o       = mem[head];
    commit_instr_o.valid = done[head];
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned.
  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (alloc[i] && mem[i].fu != NONE) begin
        rd_busy_o[mem[i].rd] = 1'b1;
      end
    end
    rd_busy_o[0] = 1'b0;
  end

  always_comb begin
    wb_conflict = 1'b0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      for (int q = p + 1; q < NR_WB_PORTS; q++) begin
        if (wb_valid_i[p] && wb_valid_i[q] && wb_trans_id_i[p] == wb_trans_id_i[q]) begin
          wb_conflict = 1'b1;
        end
      end
    end
  end

  // Two ports writing the same entry in one cycle is a protocol violation upstream.
  wb_unique_id : assert property (@(posedge clk_i) disable iff (rst_i) !wb_conflict);

`ifdef SB_FORWARD_EN
  logic [NR_ENTRIES-1:0][4:0]  ent_rd;
  logic [NR_ENTRIES-1:0][63:0] ent_result;

  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      ent_rd[i]     = mem[i].rd;
      ent_result[i] = mem[i].result;
    end
  end

  sb_fwd_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_fwd_rs1 (
    .rs_i            (rs1_i),
    .alloc_i         (alloc),
    .done_i          (done),
    .rd_i            (ent_rd),
    .result_i        (ent_result),
    .tail_i          (tail),
    .operand_o       (rs1_o),
    .operand_valid_o (rs1_valid_o)
  );

  sb_fwd_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_fwd_rs2 (
    .rs_i            (rs2_i),
    .alloc_i         (alloc),
    .done_i          (done),
    .rd_i            (ent_rd),
    .result_i        (ent_result),
    .tail_i          (tail),
    .operand_o       (rs2_o),
    .operand_valid_o (rs2_valid_o)
  );
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: commit scoreboard queue plus a table of issue/commit vectors.
// Forwarding checks are compiled only when SB_FORWARD_EN is defined.
module tb_scoreboard;
  import ariane_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            full;
  scoreboard_entry decoded_instr;
  logic            decoded_valid;
  scoreboard_entry issue_instr;
  logic            issue_valid;
  logic            issue_ack;
  logic [31:0]     rd_busy;
  logic [1:0]      wb_valid;
  logic [1:0][1:0] wb_tid;
  logic [1:0][63:0] wb_data;
  exception [1:0]  wb_ex;
  scoreboard_entry commit_instr;
  logic            commit_valid;
  logic            commit_ack;
`ifdef SB_FORWARD_EN
  logic [4:0]      rs1, rs2;
  logic [63:0]     rs1_val, rs2_val;
  logic            rs1_valid, rs2_valid;
`endif

  always #5 clk = ~clk;

  scoreboard dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .full_o          (full),
    .decoded_instr_i (decoded_instr),
    .decoded_valid_i (decoded_valid),
    .issue_instr_o   (issue_instr),
    .issue_valid_o   (issue_valid),
    .issue_ack_i     (issue_ack),
    .rd_busy_o       (rd_busy),
    .wb_valid_i      (wb_valid),
    .wb_trans_id_i   (wb_tid),
    .wb_data_i       (wb_data),
    .wb_ex_i         (wb_ex),
    .commit_instr_o  (commit_instr),
    .commit_valid_o  (commit_valid),
    .commit_ack_i    (commit_ack)
`ifdef SB_FORWARD_EN
    ,
    .rs1_i           (rs1),
    .rs2_i           (rs2),
    .rs1_o           (rs1_val),
    .rs2_o           (rs2_val),
    .rs1_valid_o     (rs1_valid),
    .rs2_valid_o     (rs2_valid)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  tid;
  } commit_rec_t;

  typedef struct {
    logic [4:0]  rd;
    fu_t         fu;
    logic [63:0] data;
    logic [1:0]  tid;
    logic [31:0] busy;
  } vec_t;

  commit_rec_t exp_q[$];
  logic [63:0] model_result [4];
  logic        model_exv    [4];
  logic [63:0] model_cause  [4];
  vec_t        vecs         [6];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush         = 1'b0;
    decoded_instr = '0;
    decoded_valid = 1'b0;
    issue_ack     = 1'b0;
    wb_valid      = '0;
    wb_tid        = '0;
    wb_data       = '0;
    wb_ex         = '0;
    commit_ack    = 1'b0;
`ifdef SB_FORWARD_EN
    rs1 = '0;
    rs2 = '0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_issue(input logic [4:0] rd, input fu_t fu, input logic [63:0] pc,
                          input logic [1:0] exp_tid, input logic pre_valid, input logic [63:0] cause);
    decoded_instr          = '0;
    decoded_instr.pc       = pc;
    decoded_instr.fu       = fu;
    decoded_instr.rd       = rd;
    decoded_instr.trans_id = 2'b11;
    decoded_instr.valid    = pre_valid;
    decoded_instr.ex.valid = pre_valid;
    decoded_instr.ex.cause = cause;
    decoded_valid          = 1'b1;
    issue_ack              = 1'b1;
    #1;
    check("issue_valid", issue_valid, 1'b1);
    check("issue_trans_id", issue_instr.trans_id, exp_tid);
    exp_q.push_back('{pc: pc, tid: exp_tid});
    model_result[exp_tid] = '0;
    model_exv[exp_tid]    = pre_valid;
    model_cause[exp_tid]  = cause;
    tick();
    decoded_valid = 1'b0;
    issue_ack     = 1'b0;
  endtask

  task automatic drive_wb(input int p, input logic [1:0] id, input logic [63:0] data,
                          input logic exv, input logic [63:0] cause);
    wb_valid[p]    = 1'b1;
    wb_tid[p]      = id;
    wb_data[p]     = data;
    wb_ex[p]       = '0;
    wb_ex[p].valid = exv;
    wb_ex[p].cause = cause;
    model_result[id] = data;
    if (exv) begin
      model_exv[id]   = 1'b1;
      model_cause[id] = cause;
    end
  endtask

  task automatic clear_wb();
    wb_valid = '0;
    wb_ex    = '0;
  endtask

  task automatic do_commit();
    commit_rec_t r;
    int n = 0;
    while (!commit_valid && n < 20) begin
      tick();
      n++;
    end
    check("commit_valid_wait", commit_valid, 1'b1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL commit_queue: DUT committed with no expected entry at %0t", $time);
    end else begin
      r = exp_q.pop_front();
      check("commit_trans_id", commit_instr.trans_id, r.tid);
      check("commit_pc", commit_instr.pc, r.pc);
      check("commit_result", commit_instr.result, model_result[r.tid]);
      check("commit_ex_valid", commit_instr.ex.valid, model_exv[r.tid]);
      if (model_exv[r.tid]) check("commit_ex_cause", commit_instr.ex.cause, model_cause[r.tid]);
    end
    commit_ack = 1'b1;
    tick();
    commit_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rd: 5'd3,  fu: ALU,  data: 64'h100, tid: 2'd0, busy: 32'h0000_0008};
    vecs[1] = '{rd: 5'd0,  fu: ALU,  data: 64'h101, tid: 2'd1, busy: 32'h0000_0000};
    vecs[2] = '{rd: 5'd7,  fu: MULT, data: 64'h102, tid: 2'd2, busy: 32'h0000_0080};
    vecs[3] = '{rd: 5'd9,  fu: NONE, data: 64'h103, tid: 2'd3, busy: 32'h0000_0000};
    vecs[4] = '{rd: 5'd31, fu: LSU,  data: 64'h104, tid: 2'd0, busy: 32'h8000_0000};
    vecs[5] = '{rd: 5'd12, fu: CSR,  data: 64'h105, tid: 2'd1, busy: 32'h0000_1000};

    // Reset state, then fill to full and try a fifth issue.
    do_reset();
    check("reset_full", full, 1'b0);
    check("reset_commit_valid", commit_valid, 1'b0);
    check("reset_rd_busy", rd_busy, 32'h0);
    check("reset_issue_valid", issue_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_issue(5'(i + 1), ALU, 64'h1000 + 64'(4 * i), 2'(i), 1'b0, 64'h0);
    end
    check("full_after_4", full, 1'b1);
    check("busy_after_4", rd_busy, 32'h0000_001E);
    decoded_instr    = '0;
    decoded_instr.rd = 5'd10;
    decoded_instr.fu = ALU;
    decoded_valid    = 1'b1;
    issue_ack        = 1'b1;
    #1;
    check("issue_valid_when_full", issue_valid, 1'b0);
    tick();
    clear_inputs();
    check("full_after_5th", full, 1'b1);
    check("busy_after_5th", rd_busy, 32'h0000_001E);

    // Out-of-order writeback, in-order commit.
    drive_wb(0, 2'd1, 64'h11, 1'b0, 64'h0);
    tick();
    clear_wb();
    check("commit_waits_for_head", commit_valid, 1'b0);
    drive_wb(0, 2'd0, 64'h10, 1'b0, 64'h0);
    tick();
    clear_wb();
    check("commit_after_head_wb", commit_valid, 1'b1);
    do_commit();
    do_commit();

    // Dual writeback in one cycle, exception on port 1.
    drive_wb(0, 2'd2, 64'hAA, 1'b0, 64'h0);
    drive_wb(1, 2'd3, 64'hBB, 1'b1, 64'h5);
    tick();
    clear_wb();
    do_commit();
    do_commit();
    check("empty_full", full, 1'b0);
    check("empty_busy", rd_busy, 32'h0);

    // Flush with same-cycle writeback and issue.
    for (int i = 0; i < 3; i++) begin
      do_issue(5'(i + 1), ALU, 64'h400 + 64'(4 * i), 2'(i), 1'b0, 64'h0);
    end
    flush            = 1'b1;
    wb_valid[0]      = 1'b1;
    wb_tid[0]        = 2'd0;
    wb_data[0]       = 64'h77;
    decoded_instr    = '0;
    decoded_instr.rd = 5'd8;
    decoded_instr.fu = ALU;
    decoded_valid    = 1'b1;
    issue_ack        = 1'b1;
    tick();
    clear_inputs();
    exp_q.delete();
    check("flush_full", full, 1'b0);
    check("flush_commit_valid", commit_valid, 1'b0);
    check("flush_busy", rd_busy, 32'h0);
    do_issue(5'd9, ALU, 64'h480, 2'd0, 1'b0, 64'h0);
    check("flush_no_stale_result", commit_valid, 1'b0);
    for (int i = 1; i < 4; i++) begin
      do_issue(5'd9, ALU, 64'h480 + 64'(4 * i), 2'(i), 1'b0, 64'h0);
    end
    check("flush_count_full", full, 1'b1);
    do_reset();

    // Table: six issue/writeback/commit rounds, wrapping trans_id.
    for (int i = 0; i < 6; i++) begin
      do_issue(vecs[i].rd, vecs[i].fu, 64'h2000 + vecs[i].data, vecs[i].tid, 1'b0, 64'h0);
      check($sformatf("vec%0d_busy", i), rd_busy, vecs[i].busy);
      drive_wb(i % 2, vecs[i].tid, vecs[i].data, 1'b0, 64'h0);
      tick();
      clear_wb();
      do_commit();
      check($sformatf("vec%0d_busy_cleared", i), rd_busy, 32'h0);
    end

    // Writeback to an unallocated entry is dropped.
    wb_valid[0] = 1'b1;
    wb_tid[0]   = 2'd2;
    wb_data[0]  = 64'hDEAD;
    tick();
    clear_wb();
    do_issue(5'd6, ALU, 64'h3000, 2'd2, 1'b0, 64'h0);
    check("unalloc_wb_dropped", commit_valid, 1'b0);
    drive_wb(1, 2'd2, 64'h66, 1'b0, 64'h0);
    tick();
    clear_wb();
    do_commit();

    // Fetch exception enters already valid.
    do_issue(5'd7, ALU, 64'h3004, 2'd3, 1'b1, 64'h1);
    check("prevalid_commit_ready", commit_valid, 1'b1);
    do_commit();

    // Spurious acks while empty are ignored.
    issue_ack  = 1'b1;
    commit_ack = 1'b1;
    tick();
    clear_inputs();
    check("spurious_ack_commit_valid", commit_valid, 1'b0);
    check("spurious_ack_full", full, 1'b0);
    do_issue(5'd4, ALU, 64'h3008, 2'd0, 1'b0, 64'h0);
    drive_wb(0, 2'd0, 64'h4242, 1'b0, 64'h0);
    tick();
    clear_wb();
    do_commit();

`ifdef SB_FORWARD_EN
    do_reset();
    do_issue(5'd5, ALU, 64'h600, 2'd0, 1'b0, 64'h0);
    drive_wb(0, 2'd0, 64'h1234, 1'b0, 64'h0);
    tick();
    clear_wb();
    rs1 = 5'd5;
    rs2 = 5'd0;
    #1;
    check("fwd_rs1_valid", rs1_valid, 1'b1);
    check("fwd_rs1_data", rs1_val, 64'h1234);
    check("fwd_rs2_zero", rs2_valid, 1'b0);
    do_issue(5'd5, ALU, 64'h604, 2'd1, 1'b0, 64'h0);
    check("fwd_younger_unwritten", rs1_valid, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
